prog_sequencer: RTL



---
 rtl/prog_sequencer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/prog_sequencer.sv
// -----------------------------------------------------------------------------
// prog_sequencer
//
// Fetch/execute controller for a small instruction memory. The program counter
// drives `sel`. The memory answers with `op`/`data`, and the controller samples
// that pair once `sel` has been held for MEM_WAIT cycles. Each instruction then
// runs on an accumulator datapath (`acc`, operand `r`). A DISP instruction
// publishes a snapshot of `acc` on `disp_value`.
//
// Optional feature (macro PROG_SEQUENCER_TRAP_EN):
//   defined   - an illegal opcode (5..31) stops the machine in TRAP with
//               `error` high. `acc`, `r` and `pc` keep their values.
//   undefined - an illegal opcode is a NOP, TRAP is unreachable and `error`
//               is tied to 0.
//
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   start       in   run request, honoured only in IDLE/DONE/TRAP
//   sel         out  [4:0] instruction address (program counter)
//   op          in   [4:0] opcode from memory
//   data        in   [4:0] immediate from memory, zero-extended to ACC_W
//   disp_value  out  [ACC_W-1:0] accumulator snapshot taken by DISP
//   disp_valid  out  one-cycle pulse when disp_value updates
//   busy        out  high in WAIT and EXEC
//   done        out  high in DONE
//   error       out  high in TRAP
//
// Handshake: `start` is a level request sampled on a rising edge while the
// controller is not busy. While busy it is ignored.
// -----------------------------------------------------------------------------
module prog_sequencer #(
    parameter int PROG_LEN = 5,
    parameter int ACC_W    = 8,
    parameter int MEM_WAIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [4:0]       sel,
    input  logic [4:0]       op,
    input  logic [4:0]       data,
    output logic [ACC_W-1:0] disp_value,
    output logic             disp_valid,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam int CNT_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_EXEC,
        S_DONE,
        S_TRAP
    } state_t;

    state_t           state_q;
    logic [4:0]       pc_q;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] r_q, r_d;
    logic [CNT_W-1:0] cnt_q;
    logic [ACC_W-1:0] disp_value_q;
    logic             disp_valid_q;
    logic             busy_q;
    logic             done_q;
    logic             disp_en_d;
`ifdef PROG_SEQUENCER_TRAP_EN
    logic             error_q;
    logic             illegal_d;
`endif

    // Datapath decode. The results are only committed in EXEC. Every read
    // here uses the pre-update register values, so ADDLD adds the old `r`.
    always_comb begin
        acc_d     = acc_q;
        r_d       = r_q;
        disp_en_d = 1'b0;
`ifdef PROG_SEQUENCER_TRAP_EN
        illegal_d = 1'b0;
`endif
        case (op)
            5'd0: begin
                acc_d = '0;
                r_d   = ACC_W'(data);
            end
            5'd1: begin
                acc_d = acc_q + r_q;
                r_d   = ACC_W'(data);
            end
            5'd2: acc_d = acc_q + r_q;
            5'd3: acc_d = acc_q >> 1;
            5'd4: disp_en_d = 1'b1;
            default: begin
`ifdef PROG_SEQUENCER_TRAP_EN
                illegal_d = 1'b1;
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pc_q         <= '0;
            acc_q        <= '0;
            r_q          <= '0;
            cnt_q        <= '0;
            disp_value_q <= '0;
            disp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef PROG_SEQUENCER_TRAP_EN
            error_q      <= 1'b0;
`endif
        end else begin
            disp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_TRAP: begin
                    if (start) begin
                        state_q <= S_WAIT;
                        pc_q    <= '0;
                        acc_q   <= '0;
                        r_q     <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
`ifdef PROG_SEQUENCER_TRAP_EN
                        error_q <= 1'b0;
`endif
                    end
                end
                // `sel` is held here for MEM_WAIT cycles before EXEC samples.
                S_WAIT: begin
                    if (cnt_q == CNT_W'(MEM_WAIT - 1)) begin
                        state_q <= S_EXEC;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_EXEC: begin
                    cnt_q <= '0;
`ifdef PROG_SEQUENCER_TRAP_EN
                    if (illegal_d) begin
                        state_q <= S_TRAP;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                    end else
`endif
                    begin
                        acc_q <= acc_d;
                        r_q   <= r_d;
                        if (disp_en_d) begin
                            disp_value_q <= acc_q;
                            disp_valid_q <= 1'b1;
                        end
                        // The last instruction stays on `sel`, so the PC
                        // does not advance past PROG_LEN-1.
                        if (pc_q == 5'(PROG_LEN - 1)) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            pc_q    <= pc_q + 5'd1;
                            state_q <= S_WAIT;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign sel        = pc_q;
    assign disp_value = disp_value_q;
    assign disp_valid = disp_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
`ifdef PROG_SEQUENCER_TRAP_EN
    assign error      = error_q;
`else
    assign error      = 1'b0;
`endif

endmodule
